rat_path_replayer: RTL and testbench

- Sits directly downstream of the rat datapath's Move output.
- Records each 2-bit move the controller emits while the rat unwinds its solution stack.
- When the controller signals completion, replays the recorded moves from the maze origin.
- Streams the resulting (x, y) cell coordinates over a valid/ready interface to the display/checker stage, flagging out-of-maze moves and whether (15,15) was reached.

---
 rtl/rat_path_replayer.sv | 156 +++++++++++++++
 tb/tb_rat_path_replayer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rat_path_replayer.sv
// Records rat moves, then replays them from (0,0) as a stream of cell coordinates.
// Out-of-maze moves are flagged and held; reaching the far corner is reported.
module rat_path_replayer #(
    parameter int DEPTH   = 256,
    parameter int COORD_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     move_valid,
    input  logic [1:0]               move,
    input  logic                     path_done,
    input  logic                     clear,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [COORD_W-1:0]       out_x,
    output logic [COORD_W-1:0]       out_y,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   path_len,
    output logic                     overflow,
    output logic                     bad_move,
    output logic                     reached,
    output logic                     busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {S_COLLECT, S_REPLAY, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_mem [DEPTH];
    logic [LW-1:0]      r_len;
    logic [LW-1:0]      r_rd;
    logic [1:0]         r_mv;
    logic               r_mv_valid;
    logic               r_mv_last;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               r_valid;
    logic               r_last;
    logic               r_ovf;
    logic               r_bad;
    logic               r_reached;

    logic               w_full;
    logic               w_push;
    logic               w_load;
    logic               w_fetch;
    logic               w_fin;
    logic               w_bad;
    logic [COORD_W-1:0] w_nx;
    logic [COORD_W-1:0] w_ny;

    assign w_full  = (r_len == LW'(DEPTH));
    assign w_push  = (r_state == S_COLLECT) && move_valid && !w_full;
    assign w_load  = (r_state == S_REPLAY) && r_mv_valid
                     && (!r_valid || out_ready);
    assign w_fetch = (r_state == S_REPLAY) && (r_rd != r_len)
                     && (!r_mv_valid || w_load);
    assign w_fin   = (r_state == S_REPLAY) && r_valid && out_ready && r_last;

    always_comb begin
        w_bad = 1'b0;
        w_nx  = r_x;
        w_ny  = r_y;
        unique case (r_mv)
            2'b00: begin w_bad = (r_x == '0); w_nx = r_x - COORD_W'(1); end
            2'b01: begin w_bad = (r_y == '1); w_ny = r_y + COORD_W'(1); end
            2'b10: begin w_bad = (r_y == '0); w_ny = r_y - COORD_W'(1); end
            2'b11: begin w_bad = (r_x == '1); w_nx = r_x + COORD_W'(1); end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_COLLECT;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_COLLECT: if (path_done)
                w_next = (r_len != '0 || w_push) ? S_REPLAY : S_DONE;
            S_REPLAY:  if (w_fin) w_next = S_DONE;
            S_DONE:    if (clear) w_next = S_COLLECT;
            default:   w_next = S_COLLECT;
        endcase
    end

    // Path storage needs no reset: only entries below r_len are ever read.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_len[AW-1:0]] <= move;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len      <= '0;
            r_rd       <= '0;
            r_mv       <= '0;
            r_mv_valid <= 1'b0;
            r_mv_last  <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_ovf      <= 1'b0;
            r_bad      <= 1'b0;
            r_reached  <= 1'b0;
        end else if (r_state == S_DONE && clear) begin
            r_len      <= '0;
            r_rd       <= '0;
            r_mv_valid <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_ovf      <= 1'b0;
            r_bad      <= 1'b0;
            r_reached  <= 1'b0;
        end else begin
            if (w_push) r_len <= r_len + LW'(1);
            if (r_state == S_COLLECT && move_valid && w_full) r_ovf <= 1'b1;
            // One-entry prefetch stage keeps 1 beat/cycle under backpressure.
            if (w_fetch) begin
                r_mv      <= r_mem[r_rd[AW-1:0]];
                r_rd      <= r_rd + LW'(1);
                r_mv_last <= ((r_rd + LW'(1)) == r_len);
            end
            if (w_fetch)     r_mv_valid <= 1'b1;
            else if (w_load) r_mv_valid <= 1'b0;
            if (w_load) begin
                r_valid <= 1'b1;
                r_last  <= r_mv_last;
                if (w_bad) begin
                    r_bad <= 1'b1;
                end else begin
                    r_x <= w_nx;
                    r_y <= w_ny;
                end
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
            if (w_fin) r_reached <= (r_x == '1) && (r_y == '1);
        end
    end

    assign out_valid = r_valid;
    assign out_x     = r_x;
    assign out_y     = r_y;
    assign out_last  = r_last;
    assign path_len  = r_len;
    assign overflow  = r_ovf;
    assign bad_move  = r_bad;
    assign reached   = r_reached;
    assign busy      = (r_state == S_REPLAY);
endmodule

// File: tb/tb_rat_path_replayer.sv
// Scoreboard bench for rat_path_replayer: random and directed paths against
// a coordinate-walk reference model.
module tb_rat_path_replayer;
    localparam int DEPTH = 32;
    localparam int CW    = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int MAXC  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          move_valid = 1'b0;
    logic [1:0]    move = 2'b00;
    logic          path_done = 1'b0;
    logic          clear = 1'b0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [CW-1:0] out_x;
    logic [CW-1:0] out_y;
    logic          out_last;
    logic [LW-1:0] path_len;
    logic          overflow;
    logic          bad_move;
    logic          reached;
    logic          busy;

    rat_path_replayer #(.DEPTH(DEPTH), .COORD_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .move_valid (move_valid),
        .move       (move),
        .path_done  (path_done),
        .clear      (clear),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_last   (out_last),
        .path_len   (path_len),
        .overflow   (overflow),
        .bad_move   (bad_move),
        .reached    (reached),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        bit last;
    } beat_t;

    beat_t      exp_q[$];
    beat_t      mon_b;
    int         n_vec = 0;
    int         n_err = 0;
    int         rmode = 0;
    logic [1:0] q[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: walk the stored prefix of the path, clamping at the walls.
    task automatic model(input logic [1:0] mv[$], output int n,
                         output int fx, output int fy, output bit bad);
        beat_t b;
        fx  = 0;
        fy  = 0;
        bad = 0;
        n   = (mv.size() > DEPTH) ? DEPTH : mv.size();
        for (int i = 0; i < n; i++) begin
            case (mv[i])
                2'd0: if (fx == 0) bad = 1; else fx--;
                2'd1: if (fy == MAXC) bad = 1; else fy++;
                2'd2: if (fy == 0) bad = 1; else fy--;
                default: if (fx == MAXC) bad = 1; else fx++;
            endcase
            b.x    = fx;
            b.y    = fy;
            b.last = (i == n - 1);
            exp_q.push_back(b);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    logic          prev_stall = 1'b0;
    logic [CW-1:0] px;
    logic [CW-1:0] py;
    logic          pl;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_x", out_x, px);
                chk("hold_y", out_y, py);
                chk("hold_last", out_last, pl);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    mon_b = exp_q.pop_front();
                    chk("beat_x", out_x, mon_b.x);
                    chk("beat_y", out_y, mon_b.y);
                    chk("beat_last", out_last, mon_b.last);
                end
            end
            prev_stall = out_valid && !out_ready;
            px = out_x;
            py = out_y;
            pl = out_last;
        end
    end

    task automatic drive_moves(input logic [1:0] mv[$], input bit with_last);
        for (int i = 0; i < mv.size(); i++) begin
            move_valid = 1'b1;
            move       = mv[i];
            path_done  = with_last && (i == mv.size() - 1);
            @(posedge clk); #1;
        end
        move_valid = 1'b0;
        path_done  = 1'b0;
        if (!with_last || mv.size() == 0) begin
            path_done = 1'b1;
            @(posedge clk); #1;
            path_done = 1'b0;
        end
    endtask

    task automatic run_path(input logic [1:0] mv[$], input int rm,
                            input bit with_last);
        int n;
        int fx;
        int fy;
        bit bad;
        int t;
        model(mv, n, fx, fy, bad);
        rmode = rm;
        drive_moves(mv, with_last);
        if (n > 0) begin
            chk("lat0_valid", out_valid, 0);
            chk("lat0_busy", busy, 1);
            @(posedge clk); #1;
            chk("lat1_valid", out_valid, 0);
            @(posedge clk); #1;
            chk("lat2_valid", out_valid, 1);
        end
        t = 0;
        while (busy && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        chk("replay_timeout", (t < 2000), 1);
        @(negedge clk); #1;
        chk("beats_left", exp_q.size(), 0);
        exp_q.delete();
        chk("done_valid", out_valid, 0);
        chk("path_len", path_len, n);
        chk("overflow", overflow, (mv.size() > DEPTH));
        chk("bad_move", bad_move, bad);
        chk("reached", reached, (n > 0 && fx == MAXC && fy == MAXC));
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("clr_len", path_len, 0);
        chk("clr_flags", {overflow, bad_move, reached, busy}, 0);
    endtask

    initial begin
        int n;
        int fx;
        int fy;
        bit bad;
        int t;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", {out_valid, out_x, out_y, out_last}, 0);
        chk("rst_len", path_len, 0);
        chk("rst_flags", {overflow, bad_move, reached, busy}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        q = {2'd3, 2'd1, 2'd3};
        run_path(q, 0, 0);
        run_path(q, 1, 0);

        q = {};
        for (int i = 0; i < 15; i++) q.push_back(2'd3);
        for (int i = 0; i < 15; i++) q.push_back(2'd1);
        run_path(q, 0, 1);

        q = {};
        for (int i = 0; i < 17; i++) begin
            q.push_back(2'd3);
            q.push_back(2'd0);
        end
        run_path(q, 2, 0);

        q = {};
        for (int i = 0; i < 20; i++) q.push_back(2'd3);
        run_path(q, 1, 1);

        q = {2'd0, 2'd3};
        run_path(q, 0, 0);

        q = {};
        run_path(q, 0, 0);

        for (int k = 0; k < 20; k++) begin
            q = {};
            for (int i = 0; i < $urandom_range(1, 40); i++)
                q.push_back(2'($urandom_range(0, 3)));
            run_path(q, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        q = {2'd1, 2'd3, 2'd1, 2'd3, 2'd1};
        model(q, n, fx, fy, bad);
        rmode = 0;
        drive_moves(q, 0);
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("rst_wait", (t < 50), 1);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_len", path_len, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        q = {2'd1};
        run_path(q, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
